// File: rtl/cache_arbiter.sv
// cache_arbiter
//   Two-port line-request arbiter between the split L1 caches and the single
//   cacheline adaptor. One request is serviced at a time. Ties in IDLE go to
//   the side that was not granted last. The read line is buffered and
//   returned to both caches, and only the owner receives the resp pulse.
//
// Ports:
//   clk, reset_n            clock, asynchronous active-low reset
//   i_address_i/i_read_i    I-cache line read request (level, held until i_resp_o)
//   i_line_o/i_resp_o       line and completion pulse to I-cache
//   d_address_i/d_read_i/d_write_i/d_line_i
//                           D-cache read/write request (level, held until d_resp_o)
//   d_line_o/d_resp_o       line and completion pulse to D-cache
//   mem_address_o/mem_read_o/mem_write_o/mem_line_o
//                           request to the cacheline adaptor
//   mem_line_i/mem_resp_i   adaptor read line and one-cycle completion pulse
module cache_arbiter #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned LINE_W = 256
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] i_address_i,
  input  logic              i_read_i,
  output logic [LINE_W-1:0] i_line_o,
  output logic              i_resp_o,
  input  logic [ADDR_W-1:0] d_address_i,
  input  logic              d_read_i,
  input  logic              d_write_i,
  input  logic [LINE_W-1:0] d_line_i,
  output logic [LINE_W-1:0] d_line_o,
  output logic              d_resp_o,
  output logic [ADDR_W-1:0] mem_address_o,
  output logic              mem_read_o,
  output logic              mem_write_o,
  output logic [LINE_W-1:0] mem_line_o,
  input  logic [LINE_W-1:0] mem_line_i,
  input  logic              mem_resp_i
);

  typedef enum logic [1:0] {IDLE, MEM, RESP} state_t;
  typedef enum logic {SIDE_I, SIDE_D} side_t;
  typedef enum logic {OP_RD, OP_WR} op_t;

  state_t            state, state_n;
  side_t             owner;
  op_t               op;
  side_t             last_grant;
  logic [ADDR_W-1:0] abuf;
  logic [LINE_W-1:0] wbuf;
  logic [LINE_W-1:0] rbuf;

  logic d_req;
  logic grant;
  logic grant_d;

  assign d_req = d_read_i | d_write_i;

  always_comb begin
    state_n = state;
    grant   = 1'b0;
    grant_d = 1'b0;
    unique case (state)
      IDLE: begin
        grant = i_read_i | d_req;
        // On a tie the side not granted last wins; otherwise the lone requester.
        if (i_read_i && d_req) grant_d = (last_grant == SIDE_I);
        else                   grant_d = d_req;
        if (grant) state_n = MEM;
      end
      MEM:     if (mem_resp_i) state_n = RESP;
      RESP:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      owner      <= SIDE_I;
      op         <= OP_RD;
      last_grant <= SIDE_I;
      abuf       <= '0;
      wbuf       <= '0;
      rbuf       <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && grant) begin
        abuf       <= grant_d ? d_address_i : i_address_i;
        owner      <= grant_d ? SIDE_D : SIDE_I;
        last_grant <= grant_d ? SIDE_D : SIDE_I;
        // Write wins when the D-cache raises both read and write.
        if (grant_d && d_write_i) begin
          op   <= OP_WR;
          wbuf <= d_line_i;
        end else begin
          op <= OP_RD;
        end
      end
      if (state == MEM && mem_resp_i && op == OP_RD) rbuf <= mem_line_i;
    end
  end

  assign mem_read_o    = (state == MEM) && (op == OP_RD);
  assign mem_write_o   = (state == MEM) && (op == OP_WR);
  assign mem_address_o = abuf;
  assign mem_line_o    = wbuf;
  assign i_resp_o      = (state == RESP) && (owner == SIDE_I);
  assign d_resp_o      = (state == RESP) && (owner == SIDE_D);
  assign i_line_o      = rbuf;
  assign d_line_o      = rbuf;

endmodule
